alsu_cmd_sequencer: RTL and testbench

Upstream command sequencer for the ALSU datapath. It buffers packed 16-bit ALSU command words in a small synchronous FIFO and drives the ALSU operand and control inputs one command at a time. Each command is held for a programmable number of cycles, so shift and rotate opcodes can run for several clocks. It also pre-screens commands against the ALSU invalid-combination rule, supports run, single-step and flush control, and reports occupancy and drop statistics.

---
 rtl/alsu_pkg.sv | 41 ++++
 rtl/alsu_cmd_fifo.sv | 53 +++++
 rtl/alsu_cmd_sequencer.sv | 148 ++++++++++++++
 tb/tb_alsu_cmd_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alsu_pkg.sv
// Shared ALSU command definitions: field layout, opcodes, sequencer states, invalid rule.
// Latency: none (types, constants and a pure function).
// Backpressure: n/a.
package alsu_pkg;

  // Command word layout: [15:13] opcode, [12:10] A, [9:7] B, then single-bit controls
  localparam int CMD_W   = 16;
  localparam int REP_W   = 4;
  localparam int ENTRY_W = CMD_W + REP_W;
  localparam int FLD_W   = 3;
  localparam int OPC_LSB = 13;
  localparam int A_LSB   = 10;
  localparam int B_LSB   = 7;
  localparam int CIN_BIT = 6;
  localparam int SIN_BIT = 5;
  localparam int DIR_BIT = 4;
  localparam int RA_BIT  = 3;
  localparam int RB_BIT  = 2;
  localparam int BA_BIT  = 1;
  localparam int BB_BIT  = 0;

  localparam logic [FLD_W-1:0] OP_AND    = 3'd0;
  localparam logic [FLD_W-1:0] OP_XOR    = 3'd1;
  localparam logic [FLD_W-1:0] OP_ADD    = 3'd2;
  localparam logic [FLD_W-1:0] OP_MUL    = 3'd3;
  localparam logic [FLD_W-1:0] OP_SHIFT  = 3'd4;
  localparam logic [FLD_W-1:0] OP_ROTATE = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } seq_state_e;

  // Opcodes 6/7 are undefined; reduction modes only make sense for AND/XOR
  function automatic logic is_invalid_cmd(input logic [FLD_W-1:0] opc,
                                          input logic red_a,
                                          input logic red_b);
    return (opc == 3'd6) || (opc == 3'd7) || ((red_a || red_b) && (opc[2] || opc[1]));
  endfunction

endpackage

// File: rtl/alsu_cmd_fifo.sv
// Generic synchronous FIFO with show-ahead read data and a synchronous clear.
// Latency: a push is visible at the head one cycle later; pop consumes on the edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/empty.
module alsu_cmd_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers and occupancy; DEPTH is a power of 2 so pointers wrap by overflow
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + CW'(1);
      else if (pop_ok && !push_ok) cnt_q <= cnt_q - CW'(1);
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/alsu_cmd_sequencer.sv
// Buffers ALSU command words and drives the ALSU one command at a time, held repeat+1 cycles.
// Latency: word written at edge k into an empty FIFO with run=1 drives the ALSU after edge k+1.
// Backpressure: cmd_ready = !full && !flush, independent of same-cycle pops.
module alsu_cmd_sequencer
  import alsu_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter bit DROP_INVALID = 1'b1,
  parameter int CNT_W        = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [15:0]                cmd_word,
  input  logic [3:0]                 cmd_repeat,
  input  logic                       run,
  input  logic                       step,
  input  logic                       flush,
  output logic [2:0]                 A,
  output logic [2:0]                 B,
  output logic [2:0]                 opcode,
  output logic                       cin,
  output logic                       serial_in,
  output logic                       direction,
  output logic                       red_op_A,
  output logic                       red_op_B,
  output logic                       bypass_A,
  output logic                       bypass_B,
  output logic                       issue_valid,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [CNT_W-1:0]           drop_count
);
  logic [ENTRY_W-1:0] head;
  logic [CMD_W-1:0]   head_word;
  logic [REP_W-1:0]   head_rep;
  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic               head_inv, can_load, can_drop, drop_inc;
  seq_state_e         state_q, state_d;
  logic [CMD_W-1:0]   drv_q, drv_d;
  logic [REP_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   drop_q;

  assign cmd_ready = !fifo_full && !flush;
  assign fifo_push = cmd_valid && cmd_ready;

  alsu_cmd_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({cmd_repeat, cmd_word}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_word = head[CMD_W-1:0];
  assign head_rep  = head[ENTRY_W-1:CMD_W];
  assign head_inv  = is_invalid_cmd(head_word[OPC_LSB +: FLD_W], head_word[RA_BIT], head_word[RB_BIT]);
  assign can_load  = !fifo_empty && (!head_inv || !DROP_INVALID);
  assign can_drop  = !fifo_empty && head_inv && DROP_INVALID;

  // Next state: issue/drop from IDLE, count down in HOLD, chain on run without a bubble
  always_comb begin
    state_d  = state_q;
    drv_d    = drv_q;
    rem_d    = rem_q;
    fifo_pop = 1'b0;
    drop_inc = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      drv_d   = '0;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // run covers the step case too; step only matters when run is low
          if (run || step) begin
            if (can_load) begin
              fifo_pop = 1'b1;
              drv_d    = head_word;
              rem_d    = head_rep;
              state_d  = ST_HOLD;
            end else if (can_drop) begin
              fifo_pop = 1'b1;
              drop_inc = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (rem_q != '0) begin
            rem_d = rem_q - REP_W'(1);
          end else if (run && can_load) begin
            fifo_pop = 1'b1;
            drv_d    = head_word;
            rem_d    = head_rep;
          end else begin
            state_d = ST_IDLE;
            drv_d   = '0;
            rem_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sequencer state, held command and remaining hold count
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      drv_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      drv_q   <= drv_d;
      rem_q   <= rem_d;
    end
  end

  // Saturating count of discarded invalid commands; flush leaves it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop_inc && (drop_q != {CNT_W{1'b1}})) begin
      drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign opcode      = drv_q[OPC_LSB +: FLD_W];
  assign A           = drv_q[A_LSB +: FLD_W];
  assign B           = drv_q[B_LSB +: FLD_W];
  assign cin         = drv_q[CIN_BIT];
  assign serial_in   = drv_q[SIN_BIT];
  assign direction   = drv_q[DIR_BIT];
  assign red_op_A    = drv_q[RA_BIT];
  assign red_op_B    = drv_q[RB_BIT];
  assign bypass_A    = drv_q[BA_BIT];
  assign bypass_B    = drv_q[BB_BIT];
  assign issue_valid = (state_q == ST_HOLD);
  assign busy        = (state_q != ST_IDLE);
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_alsu_cmd_sequencer.sv
// Directed vector bench for alsu_cmd_sequencer (DEPTH=8, DROP_INVALID=1, CNT_W=8).
// Latency: each vector is applied for one clock and checked 1 time unit after the edge.
// Backpressure: cmd_ready is checked against hand-computed occupancy and flush state.
module tb_alsu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, run, step, flush;
  logic [15:0] cmd_word;
  logic [3:0]  cmd_repeat;
  logic        cmd_ready;
  logic [2:0]  A, B, opcode;
  logic        cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
  logic        issue_valid, busy;
  logic [3:0]  fifo_count;
  logic [7:0]  drop_count;
  logic [15:0] drv;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, cv;
    logic [15:0] word;
    logic [3:0]  rep;
    logic        run, step, flush;
    logic        e_iv;
    logic [15:0] e_drv;
    logic [3:0]  e_cnt;
    logic        e_rdy;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t vecs[$];

  localparam logic [15:0] NOP = 16'h0000;

  always #5 clk = ~clk;

  alsu_cmd_sequencer #(.DEPTH(8), .DROP_INVALID(1'b1), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_word    (cmd_word),
    .cmd_repeat  (cmd_repeat),
    .run         (run),
    .step        (step),
    .flush       (flush),
    .A           (A),
    .B           (B),
    .opcode      (opcode),
    .cin         (cin),
    .serial_in   (serial_in),
    .direction   (direction),
    .red_op_A    (red_op_A),
    .red_op_B    (red_op_B),
    .bypass_A    (bypass_A),
    .bypass_B    (bypass_B),
    .issue_valid (issue_valid),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .drop_count  (drop_count)
  );

  assign drv = {opcode, A, B, cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B};

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                     input logic c, input logic si, input logic dir,
                                     input logic ra, input logic rb, input logic ba, input logic bb);
    return {op, a, b, c, si, dir, ra, rb, ba, bb};
  endfunction

  task automatic add(input int r, input int cv, input logic [15:0] w, input int rep,
                     input int rn, input int st, input int fl,
                     input int iv, input logic [15:0] edrv, input int cnt, input int rdy, input int drop);
    vec_t v;
    v.rst = 1'(r);  v.cv = 1'(cv);  v.word = w;  v.rep = 4'(rep);
    v.run = 1'(rn); v.step = 1'(st); v.flush = 1'(fl);
    v.e_iv = 1'(iv); v.e_drv = edrv; v.e_cnt = 4'(cnt); v.e_rdy = 1'(rdy); v.e_drop = 8'(drop);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Watchdog: the bench must never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w1, w2, x1, x2, x3, i1, i2, vv, lw;
    logic [15:0] s[9];
    logic [15:0] f[5];
    int n;

    w1 = mk(3'd2, 3'd3, 3'd5, 1, 0, 0, 0, 0, 0, 0);
    w2 = mk(3'd4, 3'd0, 3'd0, 0, 1, 1, 0, 0, 0, 0);
    x1 = mk(3'd0, 3'd1, 3'd2, 0, 0, 0, 0, 0, 0, 1);
    x2 = mk(3'd1, 3'd4, 3'd6, 1, 0, 0, 1, 0, 0, 0);
    x3 = mk(3'd3, 3'd7, 3'd1, 0, 0, 0, 0, 0, 1, 0);
    i1 = mk(3'd6, 3'd1, 3'd1, 0, 0, 0, 0, 0, 0, 0);
    i2 = mk(3'd2, 3'd2, 3'd2, 0, 0, 0, 1, 0, 0, 0);
    vv = mk(3'd0, 3'd7, 3'd7, 0, 0, 0, 0, 0, 0, 0);
    lw = mk(3'd5, 3'd6, 3'd3, 1, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) s[i] = mk(3'd1, 3'(i), 3'(7 - i), 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) f[i] = mk(3'd5, 3'(i), 3'd2, 0, 1, 0, 0, 0, 1, 0);

    // rst cv word rep run step flush | iv drv cnt rdy drop
    add(1, 0, NOP, 0, 0, 0, 0,   0, NOP, 0, 1, 0);
    // single repeat=0 command, one-edge latency
    add(0, 1, w1, 0, 1, 0, 0,    0, NOP, 1, 1, 0);
    add(0, 0, NOP, 0, 1, 0, 0,   1, w1,  0, 1, 0);
    add(0, 0, NOP, 0, 1, 0, 0,   0, NOP, 0, 1, 0);
    // repeat=3 shift: held four cycles
    add(0, 1, w2, 3, 1, 0, 0,    0, NOP, 1, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 0, NOP, 0, 1, 0, 0, 1, w2, 0, 1, 0);
    add(0, 0, NOP, 0, 1, 0, 0,   0, NOP, 0, 1, 0);
    // back-to-back issue with simultaneous push/pop
    add(0, 1, x1, 0, 1, 0, 0,    0, NOP, 1, 1, 0);
    add(0, 1, x2, 0, 1, 0, 0,    1, x1,  1, 1, 0);
    add(0, 1, x3, 0, 1, 0, 0,    1, x2,  1, 1, 0);
    add(0, 0, NOP, 0, 1, 0, 0,   1, x3,  0, 1, 0);
    add(0, 0, NOP, 0, 1, 0, 0,   0, NOP, 0, 1, 0);
    // two invalid heads dropped, then a valid one issued
    add(0, 1, i1, 0, 1, 0, 0,    0, NOP, 1, 1, 0);
    add(0, 1, i2, 0, 1, 0, 0,    0, NOP, 1, 1, 1);
    add(0, 1, vv, 0, 1, 0, 0,    0, NOP, 1, 1, 2);
    add(0, 0, NOP, 0, 1, 0, 0,   1, vv,  0, 1, 2);
    add(0, 0, NOP, 0, 1, 0, 0,   0, NOP, 0, 1, 2);
    // fill to full with run=0, ninth write refused, then step behaviour
    for (int i = 0; i < 8; i++) add(0, 1, s[i], (i == 0) ? 2 : 0, 0, 0, 0, 0, NOP, i + 1, (i < 7) ? 1 : 0, 2);
    add(0, 1, s[8], 0, 0, 0, 0,  0, NOP, 8, 0, 2);
    add(0, 0, NOP, 0, 0, 1, 0,   1, s[0], 7, 1, 2);
    add(0, 0, NOP, 0, 0, 1, 0,   1, s[0], 7, 1, 2);
    add(0, 0, NOP, 0, 0, 0, 0,   1, s[0], 7, 1, 2);
    add(0, 0, NOP, 0, 0, 0, 0,   0, NOP, 7, 1, 2);
    add(0, 0, NOP, 0, 0, 0, 0,   0, NOP, 7, 1, 2);
    // flush with a simultaneous write: write refused, FIFO emptied
    add(0, 1, s[8], 0, 0, 0, 1,  0, NOP, 0, 0, 2);
    // flush in cycle 2 of a repeat=5 hold with 4 queued
    for (int i = 0; i < 5; i++) add(0, 1, f[i], (i == 0) ? 5 : 0, 0, 0, 0, 0, NOP, i + 1, 1, 2);
    add(0, 0, NOP, 0, 0, 1, 0,   1, f[0], 4, 1, 2);
    add(0, 0, NOP, 0, 0, 0, 0,   1, f[0], 4, 1, 2);
    add(0, 0, NOP, 0, 0, 0, 1,   0, NOP, 0, 0, 2);
    add(0, 0, NOP, 0, 0, 0, 0,   0, NOP, 0, 1, 2);
    // same sequence aborted by reset instead
    for (int i = 0; i < 5; i++) add(0, 1, f[i], (i == 0) ? 5 : 0, 0, 0, 0, 0, NOP, i + 1, 1, 2);
    add(0, 0, NOP, 0, 0, 1, 0,   1, f[0], 4, 1, 2);
    add(0, 0, NOP, 0, 0, 0, 0,   1, f[0], 4, 1, 2);
    add(1, 0, NOP, 0, 0, 0, 0,   0, NOP, 0, 1, 0);
    add(0, 0, NOP, 0, 1, 0, 0,   0, NOP, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst        = vecs[i].rst;
      cmd_valid  = vecs[i].cv;
      cmd_word   = vecs[i].word;
      cmd_repeat = vecs[i].rep;
      run        = vecs[i].run;
      step       = vecs[i].step;
      flush      = vecs[i].flush;
      @(posedge clk);
      #1;
      chk("issue_valid", i, 16'(issue_valid), 16'(vecs[i].e_iv));
      chk("busy",        i, 16'(busy),        16'(vecs[i].e_iv));
      chk("drive",       i, drv,              vecs[i].e_drv);
      chk("fifo_count",  i, 16'(fifo_count),  16'(vecs[i].e_cnt));
      chk("cmd_ready",   i, 16'(cmd_ready),   16'(vecs[i].e_rdy));
      chk("drop_count",  i, 16'(drop_count),  16'(vecs[i].e_drop));
    end

    // Maximum repeat with run and step both high: 16-cycle hold, run takes priority
    rst = 1'b0; flush = 1'b0;
    cmd_valid = 1'b1; cmd_word = lw; cmd_repeat = 4'd15; run = 1'b1; step = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_word = NOP; cmd_repeat = 4'd0; step = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        chk("maxrep_first_iv",  c, 16'(issue_valid), 16'd1);
        chk("maxrep_first_drv", c, drv, lw);
      end
      if (issue_valid) n++;
    end
    chk("maxrep_hold_cycles", 0, 16'(n), 16'd16);
    chk("maxrep_end_iv",      0, 16'(issue_valid), 16'd0);
    chk("maxrep_end_drive",   0, drv, NOP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
